// File: rtl/bus_control_sequencer_if.sv
// Control-bus bundle between the microcode sequencer (master) and the
// breadboard CPU register file / datapath (slave).
interface bus_control_sequencer_if #(
    parameter int OPW = 4
);
    // Sequencer inputs: run control, instruction register and flag register.
    logic           run;
    logic [OPW-1:0] opcode;
    logic           flag_c;
    logic           flag_z;

    // Active-low register gate and output-enable controls.
    logic           pc_oe_n;
    logic           pc_inc;
    logic           pc_load_n;
    logic           mar_load_n;
    logic           ram_oe_n;
    logic           ram_load_n;
    logic           ir_load_n;
    logic           ir_oe_n;
    logic           a_load_n;
    logic           a_oe_n;
    logic           b_load_n;
    logic           alu_oe_n;
    logic           alu_sub;
    logic           out_load_n;
    logic           flags_load_n;

    // Sequencer status.
    logic           halted;
    logic [2:0]     step;

    modport master (
        input  run, opcode, flag_c, flag_z,
        output pc_oe_n, pc_inc, pc_load_n, mar_load_n, ram_oe_n, ram_load_n,
               ir_load_n, ir_oe_n, a_load_n, a_oe_n, b_load_n, alu_oe_n,
               alu_sub, out_load_n, flags_load_n, halted, step
    );

    modport slave (
        output run, opcode, flag_c, flag_z,
        input  pc_oe_n, pc_inc, pc_load_n, mar_load_n, ram_oe_n, ram_load_n,
               ir_load_n, ir_oe_n, a_load_n, a_oe_n, b_load_n, alu_oe_n,
               alu_sub, out_load_n, flags_load_n, halted, step
    );
endinterface

// File: rtl/bus_control_sequencer.sv
// Microcode control sequencer for the 8-bit breadboard CPU. Steps through a
// fixed number of T-states per instruction and decodes opcode/flags into the
// register load and bus-drive enables. Each step drives at most one bus source.
module bus_control_sequencer #(
    parameter int STEPS = 5
) (
    input logic                      CLK,
    input logic                      CLR,
    bus_control_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        T0, T1, T2, T3, T4, T5, T6, T7
    } t_state_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_LDA = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_STA = 4'b0100,
        OP_LDI = 4'b0101,
        OP_JMP = 4'b0110,
        OP_JC  = 4'b0111,
        OP_JZ  = 4'b1000,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } op_e;

    typedef struct packed {
        logic pc_oe_n;
        logic pc_inc;
        logic pc_load_n;
        logic mar_load_n;
        logic ram_oe_n;
        logic ram_load_n;
        logic ir_load_n;
        logic ir_oe_n;
        logic a_load_n;
        logic a_oe_n;
        logic b_load_n;
        logic alu_oe_n;
        logic alu_sub;
        logic out_load_n;
        logic flags_load_n;
    } ctrl_t;

    // Every enable deasserted: active-low controls high, active-high ones low.
    localparam ctrl_t CTRL_IDLE = '{pc_inc: 1'b0, alu_sub: 1'b0, default: 1'b1};
    localparam t_state_e LAST   = t_state_e'(3'(STEPS - 1));

    t_state_e state_q, state_d;
    logic     halted_q, halted_d;
    logic     active;
    op_e      op;
    ctrl_t    ctrl;

    assign op     = op_e'(bus.opcode[3:0]);
    assign active = bus.run && !halted_q && !CLR;

    // Step and halt registers; reset abandons any instruction in flight.
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (CLR) begin
            state_q  <= T0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Next step / halt decision and the combinational control word.
    always_comb begin
        // NOTE: every variable gets a default before the case tree so no
        // path can leave a value unassigned and infer a latch.
        state_d  = state_q;
        halted_d = halted_q;
        ctrl     = CTRL_IDLE;

        if (active) begin
            if (op == OP_HLT && state_q == T2) begin
                halted_d = 1'b1;
            end else begin
                state_d = (state_q == LAST) ? T0 : t_state_e'(state_q + 3'd1);
            end

            case (state_q)
                T0: begin
                    ctrl.pc_oe_n    = 1'b0;
                    ctrl.mar_load_n = 1'b0;
                end
                T1: begin
                    ctrl.ram_oe_n  = 1'b0;
                    ctrl.ir_load_n = 1'b0;
                    ctrl.pc_inc    = 1'b1;
                end
                T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl.ir_oe_n    = 1'b0;
                            ctrl.mar_load_n = 1'b0;
                        end
                        OP_LDI: begin
                            ctrl.ir_oe_n  = 1'b0;
                            ctrl.a_load_n = 1'b0;
                        end
                        OP_JMP: begin
                            ctrl.ir_oe_n   = 1'b0;
                            ctrl.pc_load_n = 1'b0;
                        end
                        OP_JC: begin
                            ctrl.ir_oe_n   = !bus.flag_c;
                            ctrl.pc_load_n = !bus.flag_c;
                        end
                        OP_JZ: begin
                            ctrl.ir_oe_n   = !bus.flag_z;
                            ctrl.pc_load_n = !bus.flag_z;
                        end
                        OP_OUT: begin
                            ctrl.a_oe_n     = 1'b0;
                            ctrl.out_load_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (op)
                        OP_LDA: begin
                            ctrl.ram_oe_n = 1'b0;
                            ctrl.a_load_n = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.ram_oe_n = 1'b0;
                            ctrl.b_load_n = 1'b0;
                        end
                        OP_STA: begin
                            ctrl.a_oe_n     = 1'b0;
                            ctrl.ram_load_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        ctrl.alu_oe_n     = 1'b0;
                        ctrl.a_load_n     = 1'b0;
                        ctrl.flags_load_n = 1'b0;
                        ctrl.alu_sub      = (op == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_oe_n      = ctrl.pc_oe_n;
    assign bus.pc_inc       = ctrl.pc_inc;
    assign bus.pc_load_n    = ctrl.pc_load_n;
    assign bus.mar_load_n   = ctrl.mar_load_n;
    assign bus.ram_oe_n     = ctrl.ram_oe_n;
    assign bus.ram_load_n   = ctrl.ram_load_n;
    assign bus.ir_load_n    = ctrl.ir_load_n;
    assign bus.ir_oe_n      = ctrl.ir_oe_n;
    assign bus.a_load_n     = ctrl.a_load_n;
    assign bus.a_oe_n       = ctrl.a_oe_n;
    assign bus.b_load_n     = ctrl.b_load_n;
    assign bus.alu_oe_n     = ctrl.alu_oe_n;
    assign bus.alu_sub      = ctrl.alu_sub;
    assign bus.out_load_n   = ctrl.out_load_n;
    assign bus.flags_load_n = ctrl.flags_load_n;
    assign bus.halted       = halted_q;
    assign bus.step         = state_q;

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Self-checking bench for bus_control_sequencer: directed instruction runs,
// halt/reset, run-freeze, mid-T2 flag change, then a long random soak.
module tb_bus_control_sequencer;

    localparam int STEPS = 5;

    // Bit positions of the control word as packed into obs_ctrl.
    localparam logic [14:0] M_PC_OE      = 15'h1 << 14;
    localparam logic [14:0] M_PC_INC     = 15'h1 << 13;
    localparam logic [14:0] M_PC_LOAD    = 15'h1 << 12;
    localparam logic [14:0] M_MAR_LOAD   = 15'h1 << 11;
    localparam logic [14:0] M_RAM_OE     = 15'h1 << 10;
    localparam logic [14:0] M_RAM_LOAD   = 15'h1 << 9;
    localparam logic [14:0] M_IR_LOAD    = 15'h1 << 8;
    localparam logic [14:0] M_IR_OE      = 15'h1 << 7;
    localparam logic [14:0] M_A_LOAD     = 15'h1 << 6;
    localparam logic [14:0] M_A_OE       = 15'h1 << 5;
    localparam logic [14:0] M_B_LOAD     = 15'h1 << 4;
    localparam logic [14:0] M_ALU_OE     = 15'h1 << 3;
    localparam logic [14:0] M_ALU_SUB    = 15'h1 << 2;
    localparam logic [14:0] M_OUT_LOAD   = 15'h1 << 1;
    localparam logic [14:0] M_FLAGS_LOAD = 15'h1 << 0;
    // Idle word: all high except pc_inc and alu_sub.
    localparam logic [14:0] INACT        = 15'b101111111111011;

    typedef struct packed {
        logic [14:0] ctrl;
        logic [2:0]  step;
        logic        halted;
    } exp_t;

    logic CLK = 1'b0;
    logic CLR;
    always #5 CLK = ~CLK;

    bus_control_sequencer_if #(.OPW(4)) bus ();

    bus_control_sequencer #(.STEPS(STEPS)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    logic [14:0] obs_ctrl;
    assign obs_ctrl = {bus.pc_oe_n, bus.pc_inc, bus.pc_load_n, bus.mar_load_n,
                       bus.ram_oe_n, bus.ram_load_n, bus.ir_load_n, bus.ir_oe_n,
                       bus.a_load_n, bus.a_oe_n, bus.b_load_n, bus.alu_oe_n,
                       bus.alu_sub, bus.out_load_n, bus.flags_load_n};

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] m_step;
    logic       m_halted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Signals that the microcode table says are asserted in a given step.
    function automatic logic [14:0] exp_act(input logic [3:0] op, input logic [2:0] t,
                                            input logic c, input logic z);
        logic [14:0] m;
        m = '0;
        case (t)
            3'd0: m = M_PC_OE | M_MAR_LOAD;
            3'd1: m = M_RAM_OE | M_IR_LOAD | M_PC_INC;
            3'd2: case (op)
                4'h1, 4'h2, 4'h3, 4'h4: m = M_IR_OE | M_MAR_LOAD;
                4'h5: m = M_IR_OE | M_A_LOAD;
                4'h6: m = M_IR_OE | M_PC_LOAD;
                4'h7: m = c ? (M_IR_OE | M_PC_LOAD) : '0;
                4'h8: m = z ? (M_IR_OE | M_PC_LOAD) : '0;
                4'hE: m = M_A_OE | M_OUT_LOAD;
                default: m = '0;
            endcase
            3'd3: case (op)
                4'h1: m = M_RAM_OE | M_A_LOAD;
                4'h2, 4'h3: m = M_RAM_OE | M_B_LOAD;
                4'h4: m = M_A_OE | M_RAM_LOAD;
                default: m = '0;
            endcase
            3'd4: case (op)
                4'h2: m = M_ALU_OE | M_A_LOAD | M_FLAGS_LOAD;
                4'h3: m = M_ALU_OE | M_A_LOAD | M_FLAGS_LOAD | M_ALU_SUB;
                default: m = '0;
            endcase
            default: m = '0;
        endcase
        return m;
    endfunction

    task automatic push_expected(input logic clr, input logic r, input logic [3:0] op,
                                 input logic c, input logic z);
        exp_t e;
        logic act;
        act      = r && !m_halted && !clr;
        e.ctrl   = act ? (INACT ^ exp_act(op, m_step, c, z)) : INACT;
        e.step   = m_step;
        e.halted = m_halted;
        sb_q.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        int   n_oe;
        e = sb_q.pop_front();
        check("ctrl", 32'(obs_ctrl), 32'(e.ctrl));
        check("step", 32'(bus.step), 32'(e.step));
        check("halted", 32'(bus.halted), 32'(e.halted));
        n_oe = int'(!bus.pc_oe_n) + int'(!bus.ram_oe_n) + int'(!bus.ir_oe_n)
             + int'(!bus.a_oe_n) + int'(!bus.alu_oe_n);
        check("bus_oe_multi", 32'(n_oe > 1), 32'd0);
        check("step_range", 32'(int'(bus.step) >= STEPS), 32'd0);
    endtask

    // One clock cycle: drive at negedge, check mid-low-phase, optionally flip
    // flag_z inside the same cycle and recheck, then advance the model.
    task automatic cycle(input logic clr, input logic r, input logic [3:0] op,
                         input logic c, input logic z, input logic flip_z = 1'b0);
        logic act;
        @(negedge CLK);
        CLR        = clr;
        bus.run    = r;
        bus.opcode = op;
        bus.flag_c = c;
        bus.flag_z = z;
        push_expected(clr, r, op, c, z);
        #1 compare_head();
        if (flip_z) begin
            bus.flag_z = !z;
            push_expected(clr, r, op, c, !z);
            #1 compare_head();
        end
        act = r && !m_halted && !clr;
        if (clr) begin
            m_step   = 3'd0;
            m_halted = 1'b0;
        end else if (act) begin
            if (op == 4'hF && m_step == 3'd2) m_halted = 1'b1;
            else m_step = (int'(m_step) == STEPS - 1) ? 3'd0 : m_step + 3'd1;
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
        repeat (STEPS) cycle(1'b0, 1'b1, op, c, z);
    endtask

    initial begin
        CLR        = 1'b1;
        bus.run    = 1'b0;
        bus.opcode = 4'h0;
        bus.flag_c = 1'b0;
        bus.flag_z = 1'b0;
        @(posedge CLK);
        m_step   = 3'd0;
        m_halted = 1'b0;

        // Reset held: controls inactive even with run asserted.
        cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'h0, 1'b0, 1'b0);

        // NOP twice: step sequence 0..4,0..4 with fetch-only activity.
        run_instr(4'h0, 1'b0, 1'b0);
        run_instr(4'h0, 1'b0, 1'b0);

        // Arithmetic and load/store instructions.
        run_instr(4'h3, 1'b0, 1'b0);
        run_instr(4'h2, 1'b1, 1'b1);
        run_instr(4'h1, 1'b0, 1'b0);
        run_instr(4'h5, 1'b0, 1'b0);
        run_instr(4'h6, 1'b0, 1'b0);
        run_instr(4'hE, 1'b0, 1'b0);
        run_instr(4'hA, 1'b1, 1'b1);

        // Conditional jumps, not taken then taken.
        run_instr(4'h7, 1'b0, 1'b0);
        run_instr(4'h7, 1'b1, 1'b0);
        run_instr(4'h8, 1'b0, 1'b0);
        run_instr(4'h8, 1'b0, 1'b1);

        // JZ with flag_z rising partway through T2.
        cycle(1'b0, 1'b1, 4'h8, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'h8, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'h8, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 4'h8, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 4'h8, 1'b0, 1'b1);

        // STA with run dropped for three cycles during T3.
        repeat (3) cycle(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 4'h4, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);

        // HLT: halt at end of T2, stays frozen whatever run does, CLR recovers.
        repeat (3) cycle(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            cycle(1'b0, 1'($urandom_range(0, 1)), 4'(i), 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
        run_instr(4'h0, 1'b0, 1'b0);

        // Random soak over opcode, flags, run and reset.
        for (int i = 0; i < 10000; i++)
            cycle(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 9) != 0),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_control_sequencer.md
Name: bus_control_sequencer

Overview:
- Microcode control sequencer for the 8-bit breadboard CPU.
- Acts as the initiator side of the shared-bus register interface. It generates the active-low load enables (gate inputs) and the active-low bus-drive enables (output-control inputs) for every bus register.
- Steps through fixed T-states, decodes the instruction-register opcode and flags, and guarantees that at most one bus driver is active per cycle.

Parameters:
- STEPS, 5, T-states per instruction; legal range 5..8; the step counter wraps at STEPS-1.
- OPW, 4, opcode width in bits.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge
- CLR  in  1  reset, synchronous and active-high
- run  in  1  1 = advance; 0 = freeze step and force all controls inactive
- opcode  in  OPW  instruction register upper nibble
- flag_c  in  1  carry flag register output
- flag_z  in  1  zero flag register output
- pc_oe_n  out  1  program counter drives bus (active low)
- pc_inc  out  1  program counter increment (active high)
- pc_load_n  out  1  program counter loads from bus (jump)
- mar_load_n  out  1  memory address register load
- ram_oe_n  out  1  RAM drives bus
- ram_load_n  out  1  RAM write from bus
- ir_load_n  out  1  instruction register load
- ir_oe_n  out  1  instruction register operand nibble drives bus
- a_load_n  out  1  A register load
- a_oe_n  out  1  A register drives bus
- b_load_n  out  1  B register load
- alu_oe_n  out  1  ALU result drives bus
- alu_sub  out  1  ALU subtract select
- out_load_n  out  1  output register load
- flags_load_n  out  1  flags register load
- halted  out  1  CPU halted
- step  out  3  current T-state, 0..STEPS-1

Behaviour:
- State:
  - step counter, 3 bits.
  - halted flag.
- Reset (CLR=1 at a rising edge):
  - step <= 0, halted <= 0.
  - While CLR=1, every control output is inactive: all _n outputs = 1, pc_inc = 0, alu_sub = 0.
  - Reset mid-instruction abandons it; the first cycle after CLR falls is T0.
- Advance:
  - If run=1, halted=0 and CLR=0, then step <= (step==STEPS-1) ? 0 : step+1.
  - Otherwise step holds.
- Control word:
  - Combinational decode of step, opcode, flag_c and flag_z. It is not registered.
  - Registers sample it on the same edge that advances step.
  - Forced all-inactive when run=0, halted=1 or CLR=1.
- Fetch, all opcodes:
  - T0: pc_oe_n, mar_load_n.
  - T1: ram_oe_n, ir_load_n, pc_inc.
- Execute by opcode. Steps not listed are idle; steps >=5 are always idle.
  - 0000 NOP: idle.
  - 0001 LDA: T2 ir_oe_n + mar_load_n; T3 ram_oe_n + a_load_n.
  - 0010 ADD:
    - T2 ir_oe_n + mar_load_n.
    - T3 ram_oe_n + b_load_n.
    - T4 alu_oe_n + a_load_n + flags_load_n, with alu_sub=0.
  - 0011 SUB: same as ADD, with alu_sub=1 in T4 only.
  - 0100 STA: T2 ir_oe_n + mar_load_n; T3 a_oe_n + ram_load_n.
  - 0101 LDI: T2 ir_oe_n + a_load_n.
  - 0110 JMP: T2 ir_oe_n + pc_load_n.
  - 0111 JC: T2 ir_oe_n + pc_load_n only if flag_c=1; otherwise idle.
  - 1000 JZ: T2 ir_oe_n + pc_load_n only if flag_z=1; otherwise idle.
  - 1110 OUT: T2 a_oe_n + out_load_n.
  - 1111 HLT: T2 has no bus activity; the rising edge ending T2 sets halted=1 (when run=1). step freezes at 2.
  - Unused opcodes: idle, executed as NOP.
- Halted:
  - Sticky until CLR.
  - Controls stay inactive regardless of run.
- Invariant: at most one of pc_oe_n, ram_oe_n, ir_oe_n, a_oe_n, alu_oe_n is low in any cycle. This holds for every opcode, flag and step combination.
- Fixed instruction length: no early termination, so every instruction takes exactly STEPS cycles.
- Conditional-jump flags are sampled combinationally during T2. A change in flags within T2 changes the outputs within that same cycle.
- run=0 mid-instruction:
  - step and halted hold.
  - On the cycle run returns to 1, the same step's control word is presented; no step is skipped or repeated.

Test Plan:
- CLR=1 for 2 cycles, then run=1, opcode=0000 -> step sequence 0,1,2,3,4,0; T0 shows pc_oe_n=0 and mar_load_n=0; T1 shows ram_oe_n=0, ir_load_n=0, pc_inc=1; T2-T4 all inactive.
- opcode=0011 (SUB), run=1 -> T2 ir_oe_n/mar_load_n low; T3 ram_oe_n/b_load_n low; T4 alu_oe_n/a_load_n/flags_load_n low with alu_sub=1; alu_sub=0 in all other steps.
- opcode=0111 (JC) with flag_c=0, then repeat with flag_c=1 -> T2 idle in the first run; in the second run T2 has ir_oe_n=0 and pc_load_n=0.
- opcode=1111 (HLT) -> halted=1 after the T2 edge, step stays at 2 for 10+ cycles with all controls inactive; CLR pulse -> halted=0, step=0.
- opcode=0100 (STA), drop run to 0 during T3 for 3 cycles -> step held at 3, controls inactive during the hold; when run=1 returns, a_oe_n and ram_load_n are low for exactly one cycle.
- Random opcode, flags, run and CLR for 10k cycles -> bus-driver one-hot-or-none assertion never fires, and step is never >= STEPS.
